// File: rtl/pipe_ctrl_hazard.sv
// ID-stage control unit for a 5-stage MIPS pipeline.
// Decodes the instruction in ID and resolves branches and jumps there.
// Detects load-use, branch-operand and MDU-busy hazards and inserts bubbles.
// Owns the ID/EX control register, a small MEM-stage shadow (mem_read + dest)
// and the MDU busy counter.
module pipe_ctrl_hazard #(
  parameter int REG_ADDR_W = 5,
  parameter int MDU_LAT    = 4,
  parameter bit HAS_BNE    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            id_op,
  input  logic [5:0]            id_funct,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_eq,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  if_flush,
  output logic                  pc_src,
  output logic                  jump,
  output logic                  jump_r,
  output logic                  ex_reg_write,
  output logic                  ex_alu_src,
  output logic                  ex_reg_dst,
  output logic                  ex_mem_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_to_reg,
  output logic                  ex_ra_write,
  output logic                  ex_mdu_start,
  output logic [1:0]            ex_alu_op,
  output logic                  mdu_busy,
  output logic                  illegal
);

  // Counter must hold MDU_LAT-1.
  localparam int                CNT_W    = $clog2(MDU_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MDU_LAT - 1);

  // Decoded control for the instruction currently in ID.
  logic       dec_reg_write, dec_alu_src, dec_reg_dst, dec_mem_write;
  logic       dec_mem_read, dec_mem_to_reg, dec_ra_write, dec_mdu_start;
  logic [1:0] dec_alu_op;
  logic       is_beq, is_bne, is_j, is_jal, is_jr, is_jalr;
  logic       is_mdu_op, reads_rt, dec_illegal;
  logic [REG_ADDR_W-1:0] dec_dst;

  // Hazard terms.
  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic is_branch, br_uses_rt;
  logic load_use, br_haz, mdu_haz, stall, br_taken;

  // ID/EX register (control + destination index).
  logic       ex_reg_write_q, ex_alu_src_q, ex_reg_dst_q, ex_mem_write_q;
  logic       ex_mem_read_q, ex_mem_to_reg_q, ex_ra_write_q, ex_mdu_start_q;
  logic [1:0] ex_alu_op_q;
  logic [REG_ADDR_W-1:0] ex_dst_q;
  logic       ex_reg_write_d, ex_alu_src_d, ex_reg_dst_d, ex_mem_write_d;
  logic       ex_mem_read_d, ex_mem_to_reg_d, ex_ra_write_d, ex_mdu_start_d;
  logic [1:0] ex_alu_op_d;
  logic [REG_ADDR_W-1:0] ex_dst_d;

  // MEM-stage shadow, MDU counter, sticky illegal flag.
  logic                  mem_read_q, mem_read_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic [CNT_W-1:0]      mdu_cnt_q, mdu_cnt_d;
  logic                  illegal_q, illegal_d;

  // Decode opcode/funct into control bits and instruction-class flags.
  always_comb begin
    dec_reg_write  = 1'b0;
    dec_alu_src    = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_ra_write   = 1'b0;
    dec_mdu_start  = 1'b0;
    dec_alu_op     = 2'b00;
    is_beq         = 1'b0;
    is_bne         = 1'b0;
    is_j           = 1'b0;
    is_jal         = 1'b0;
    is_jr          = 1'b0;
    is_jalr        = 1'b0;
    is_mdu_op      = 1'b0;
    reads_rt       = 1'b0;
    dec_illegal    = 1'b0;
    case (id_op)
      6'h00: begin
        // op=0/funct=0 is the all-zero NOP: every control bit stays 0.
        if (id_funct != 6'h00) begin
          case (id_funct)
            6'h08: is_jr = 1'b1;
            6'h09: begin
              is_jalr       = 1'b1;
              dec_reg_write = 1'b1;
              dec_reg_dst   = 1'b1;
            end
            6'h18, 6'h1a: begin
              is_mdu_op     = 1'b1;
              dec_mdu_start = 1'b1;
              reads_rt      = 1'b1;
            end
            6'h10, 6'h12: begin
              is_mdu_op     = 1'b1;
              dec_reg_write = 1'b1;
              dec_reg_dst   = 1'b1;
              dec_alu_op    = 2'b10;
            end
            default: begin
              dec_reg_write = 1'b1;
              dec_reg_dst   = 1'b1;
              dec_alu_op    = 2'b10;
              reads_rt      = 1'b1;
            end
          endcase
        end
      end
      6'h04: begin
        is_beq     = 1'b1;
        dec_alu_op = 2'b01;
        reads_rt   = 1'b1;
      end
      6'h05: begin
        if (HAS_BNE) begin
          is_bne     = 1'b1;
          dec_alu_op = 2'b01;
          reads_rt   = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      6'h02: is_j = 1'b1;
      6'h03: begin
        is_jal        = 1'b1;
        dec_reg_write = 1'b1;
        dec_ra_write  = 1'b1;
      end
      6'h23: begin
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
      end
      6'h2b: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        reads_rt      = 1'b1;
      end
      6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_op    = 2'b11;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Destination: $31 for jal, rd for R-format writers, rt otherwise.
    if (dec_ra_write)     dec_dst = {REG_ADDR_W{1'b1}};
    else if (dec_reg_dst) dec_dst = id_rd;
    else                  dec_dst = id_rt;
  end

  // Hazard detection against the EX and MEM stage destinations.
  always_comb begin
    ex_hit_rs  = (ex_dst_q != '0) && (ex_dst_q == id_rs);
    ex_hit_rt  = (ex_dst_q != '0) && (ex_dst_q == id_rt);
    mem_hit_rs = (mem_rd_q != '0) && (mem_rd_q == id_rs);
    mem_hit_rt = (mem_rd_q != '0) && (mem_rd_q == id_rt);
    is_branch  = is_beq | is_bne | is_jr | is_jalr;
    br_uses_rt = is_beq | is_bne;
    load_use   = ex_mem_read_q & (ex_hit_rs | (reads_rt & ex_hit_rt));
    // Branches compare in ID, so they also wait on a load still in MEM.
    br_haz     = is_branch &
                 ((ex_reg_write_q & (ex_hit_rs | (br_uses_rt & ex_hit_rt))) |
                  (mem_read_q & (mem_hit_rs | (br_uses_rt & mem_hit_rt))));
    mdu_haz    = mdu_busy & is_mdu_op;
    stall      = load_use | br_haz | mdu_haz;
    br_taken   = (is_beq & id_eq) | (is_bne & ~id_eq);
  end

  // Front-end steering: reset > stall > branch/jump redirect.
  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    if_flush   = 1'b0;
    pc_src     = 1'b0;
    jump       = 1'b0;
    jump_r     = 1'b0;
    if (rst_n && !stall) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      pc_src     = br_taken;
      jump       = is_j | is_jal;
      jump_r     = is_jr | is_jalr;
      if_flush   = br_taken | is_j | is_jal | is_jr | is_jalr;
    end
  end

  // Next-state for ID/EX, MEM shadow, MDU counter and illegal flag.
  always_comb begin
    ex_reg_write_d  = 1'b0;
    ex_alu_src_d    = 1'b0;
    ex_reg_dst_d    = 1'b0;
    ex_mem_write_d  = 1'b0;
    ex_mem_read_d   = 1'b0;
    ex_mem_to_reg_d = 1'b0;
    ex_ra_write_d   = 1'b0;
    ex_mdu_start_d  = 1'b0;
    ex_alu_op_d     = 2'b00;
    ex_dst_d        = '0;
    if (!stall) begin
      ex_reg_write_d  = dec_reg_write;
      ex_alu_src_d    = dec_alu_src;
      ex_reg_dst_d    = dec_reg_dst;
      ex_mem_write_d  = dec_mem_write;
      ex_mem_read_d   = dec_mem_read;
      ex_mem_to_reg_d = dec_mem_to_reg;
      ex_ra_write_d   = dec_ra_write;
      ex_mdu_start_d  = dec_mdu_start;
      ex_alu_op_d     = dec_alu_op;
      ex_dst_d        = dec_dst;
    end
    mem_read_d = ex_mem_read_q;
    mem_rd_d   = ex_dst_q;
    if (ex_mdu_start_d)       mdu_cnt_d = CNT_LOAD;
    else if (mdu_cnt_q != '0) mdu_cnt_d = mdu_cnt_q - 1'b1;
    else                      mdu_cnt_d = '0;
    illegal_d = illegal_q | dec_illegal;
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_reg_write_q  <= 1'b0;
      ex_alu_src_q    <= 1'b0;
      ex_reg_dst_q    <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_ra_write_q   <= 1'b0;
      ex_mdu_start_q  <= 1'b0;
      ex_alu_op_q     <= 2'b00;
      ex_dst_q        <= '0;
      mem_read_q      <= 1'b0;
      mem_rd_q        <= '0;
      mdu_cnt_q       <= '0;
      illegal_q       <= 1'b0;
    end else begin
      ex_reg_write_q  <= ex_reg_write_d;
      ex_alu_src_q    <= ex_alu_src_d;
      ex_reg_dst_q    <= ex_reg_dst_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_to_reg_q <= ex_mem_to_reg_d;
      ex_ra_write_q   <= ex_ra_write_d;
      ex_mdu_start_q  <= ex_mdu_start_d;
      ex_alu_op_q     <= ex_alu_op_d;
      ex_dst_q        <= ex_dst_d;
      mem_read_q      <= mem_read_d;
      mem_rd_q        <= mem_rd_d;
      mdu_cnt_q       <= mdu_cnt_d;
      illegal_q       <= illegal_d;
    end
  end

  assign ex_reg_write  = ex_reg_write_q;
  assign ex_alu_src    = ex_alu_src_q;
  assign ex_reg_dst    = ex_reg_dst_q;
  assign ex_mem_write  = ex_mem_write_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_mem_to_reg = ex_mem_to_reg_q;
  assign ex_ra_write   = ex_ra_write_q;
  assign ex_mdu_start  = ex_mdu_start_q;
  assign ex_alu_op     = ex_alu_op_q;
  assign mdu_busy      = (mdu_cnt_q != '0);
  assign illegal       = illegal_q;

endmodule
